// File: rtl/riscv_retire_trace_tx.sv
// Retirement trace transmitter: captures each instruction retiring from the
// MEM stage into a small trace FIFO, streams records to a consumer, keeps
// saturating pipeline statistics and stops after a halt instruction drains.
//
// Handshake: a record transfers on a rising edge where o_tvalid & i_tready &
// i_enable are all high; while o_tvalid is high and no transfer happens the
// o_t* fields hold their values. o_tvalid depends only on FIFO occupancy.
module riscv_retire_trace_tx #(
   parameter int unsigned          DATA_WIDTH  = 64,
   parameter int unsigned          INSTR_WIDTH = 32,
   parameter int unsigned          FIFO_DEPTH  = 8,
   parameter int unsigned          CNT_WIDTH   = 32,
   parameter logic [INSTR_WIDTH-1:0] HALT_INSTR = 32'h00100073
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_enable,
   input  logic                   i_valid_instr,
   input  logic                   i_flush_mem,
   input  logic                   i_stall_mem,
   input  logic                   i_stall_if,
   input  logic                   i_flush_ex,
   input  logic                   i_stall_ex,
   input  logic [DATA_WIDTH-1:0]  i_pc,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   input  logic [DATA_WIDTH-1:0]  i_result,
   output logic                   o_tvalid,
   input  logic                   i_tready,
   output logic [DATA_WIDTH-1:0]  o_tpc,
   output logic [INSTR_WIDTH-1:0] o_tinstr,
   output logic [DATA_WIDTH-1:0]  o_tresult,
   output logic [CNT_WIDTH-1:0]   o_tseq,
   output logic [CNT_WIDTH-1:0]   o_cycles,
   output logic [CNT_WIDTH-1:0]   o_fetched,
   output logic [CNT_WIDTH-1:0]   o_executed,
   output logic [CNT_WIDTH-1:0]   o_flushed_ex,
   output logic [CNT_WIDTH-1:0]   o_dropped,
   output logic                   o_overflow,
   output logic                   o_done,
   output logic [1:0]             o_dbg_state
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned REC_W = 2 * DATA_WIDTH + INSTR_WIDTH + CNT_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 was_stall_mem_q;
   logic [AW:0]          wr_ptr_q, wr_ptr_d;
   logic [AW:0]          rd_ptr_q, rd_ptr_d;
   logic [REC_W-1:0]     mem_q [FIFO_DEPTH];
   logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
   logic [CNT_WIDTH-1:0] fetched_q, fetched_d;
   logic [CNT_WIDTH-1:0] executed_q, executed_d;
   logic [CNT_WIDTH-1:0] flushed_ex_q, flushed_ex_d;
   logic [CNT_WIDTH-1:0] dropped_q, dropped_d;
   logic                 overflow_q, overflow_d;

   logic             fifo_empty, fifo_full;
   logic             retire, run_retire, push, pop, drop, active;
   logic [REC_W-1:0] head_rec;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A stall in MEM last cycle means the instruction now in MEM already
   // retired; only a fresh, unflushed instruction retires.
   assign retire     = i_enable & i_valid_instr & ~i_flush_mem & ~was_stall_mem_q;
   assign run_retire = retire & (state_q == ST_RUN);
   assign pop        = i_enable & ~fifo_empty & i_tready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push       = run_retire & (~fifo_full | pop);
   assign drop       = run_retire & fifo_full & ~pop;
   assign active     = i_enable & (state_q != ST_DONE);

   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

   // Saturating increment shared by every statistic counter.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic en);
      return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
   endfunction

   // Next values for statistics and the sticky overflow flag.
   always_comb begin
      cycles_d     = sat_inc(cycles_q, active);
      fetched_d    = sat_inc(fetched_q, active & ~i_stall_if);
      flushed_ex_d = sat_inc(flushed_ex_q, active & i_flush_ex & ~i_stall_ex);
      executed_d   = sat_inc(executed_q, run_retire);
      dropped_d    = sat_inc(dropped_q, drop);
      overflow_d   = overflow_q | drop;
   end

   // Sequential state: pointers, counters, stall history and FSM register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q         <= ST_RUN;
         was_stall_mem_q <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         cycles_q        <= '0;
         fetched_q       <= '0;
         executed_q      <= '0;
         flushed_ex_q    <= '0;
         dropped_q       <= '0;
         overflow_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cycles_q     <= cycles_d;
         fetched_q    <= fetched_d;
         executed_q   <= executed_d;
         flushed_ex_q <= flushed_ex_d;
         dropped_q    <= dropped_d;
         overflow_q   <= overflow_d;
         if (i_enable) begin
            was_stall_mem_q <= i_stall_mem;
         end
      end
   end

   // Trace storage; contents are don't-care until covered by the pointers.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {i_pc, i_instr, i_result, executed_q};
      end
   end

   // Next state: halt moves to DRAIN; DRAIN ends the edge the FIFO empties.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (run_retire && (i_instr == HALT_INSTR)) state_d = ST_DRAIN;
         ST_DRAIN: if (i_enable && (wr_ptr_d == rd_ptr_d))    state_d = ST_DONE;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_RUN;
      endcase
   end

   // Outputs: FIFO head (zero when empty), counters and FSM status.
   always_comb begin
      head_rec     = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
      o_tvalid     = ~fifo_empty;
      o_tpc        = head_rec[REC_W-1 -: DATA_WIDTH];
      o_tinstr     = head_rec[DATA_WIDTH+CNT_WIDTH +: INSTR_WIDTH];
      o_tresult    = head_rec[CNT_WIDTH +: DATA_WIDTH];
      o_tseq       = head_rec[CNT_WIDTH-1:0];
      o_cycles     = cycles_q;
      o_fetched    = fetched_q;
      o_executed   = executed_q;
      o_flushed_ex = flushed_ex_q;
      o_dropped    = dropped_q;
      o_overflow   = overflow_q;
      o_done       = (state_q == ST_DONE);
      o_dbg_state  = state_q;
   end

endmodule

// File: tb/tb_riscv_retire_trace_tx.sv
// Directed bench for riscv_retire_trace_tx; counters are 8 bits wide so
// saturation is reachable in a short run.
module tb_riscv_retire_trace_tx;

   localparam int DW    = 64;
   localparam int IW    = 32;
   localparam int DEPTH = 8;
   localparam int CW    = 8;
   localparam logic [IW-1:0] HALT = 32'h00100073;
   localparam logic [IW-1:0] NOP  = 32'h00000013;

   logic          clk = 1'b0;
   logic          reset, enable, valid_instr, flush_mem, stall_mem, stall_if;
   logic          flush_ex, stall_ex, tready;
   logic [DW-1:0] pc, result;
   logic [IW-1:0] instr;
   logic          o_tvalid, o_overflow, o_done;
   logic [DW-1:0] o_tpc, o_tresult;
   logic [IW-1:0] o_tinstr;
   logic [CW-1:0] o_tseq, o_cycles, o_fetched, o_executed, o_flushed_ex, o_dropped;
   logic [1:0]    o_dbg_state;

   int n_vec = 0;
   int n_err = 0;

   riscv_retire_trace_tx #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH),
                           .CNT_WIDTH(CW), .HALT_INSTR(HALT)) dut (
      .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_valid_instr(valid_instr),
      .i_flush_mem(flush_mem), .i_stall_mem(stall_mem), .i_stall_if(stall_if),
      .i_flush_ex(flush_ex), .i_stall_ex(stall_ex), .i_pc(pc), .i_instr(instr),
      .i_result(result), .o_tvalid(o_tvalid), .i_tready(tready), .o_tpc(o_tpc),
      .o_tinstr(o_tinstr), .o_tresult(o_tresult), .o_tseq(o_tseq), .o_cycles(o_cycles),
      .o_fetched(o_fetched), .o_executed(o_executed), .o_flushed_ex(o_flushed_ex),
      .o_dropped(o_dropped), .o_overflow(o_overflow), .o_done(o_done),
      .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      enable = 1'b1; valid_instr = 1'b0; flush_mem = 1'b0; stall_mem = 1'b0;
      stall_if = 1'b0; flush_ex = 1'b0; stall_ex = 1'b0; tready = 1'b0;
      pc = '0; instr = NOP; result = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic drive_retire(input logic [DW-1:0] p, input logic [IW-1:0] ins);
      valid_instr = 1'b1; pc = p; instr = ins; result = p + 64'h1000;
   endtask

   task automatic test_reset();
      do_reset();
      tready = 1'b0;
      drive_retire(64'h10, NOP); step();
      drive_retire(64'h14, NOP); step();
      enable = 1'b0; reset = 1'b1; step();
      n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %0b exp 0", o_tvalid); end
      n_vec++; if (o_tpc !== '0) begin n_err++; $display("FAIL reset_tpc got %0h exp 0", o_tpc); end
      n_vec++; if (o_tseq !== '0) begin n_err++; $display("FAIL reset_tseq got %0d exp 0", o_tseq); end
      n_vec++; if (o_executed !== '0) begin n_err++; $display("FAIL reset_executed got %0d exp 0", o_executed); end
      n_vec++; if (o_cycles !== '0) begin n_err++; $display("FAIL reset_cycles got %0d exp 0", o_cycles); end
      n_vec++; if (o_done !== 1'b0 || o_overflow !== 1'b0) begin n_err++; $display("FAIL reset_flags got done=%0b ovf=%0b exp 0/0", o_done, o_overflow); end
      reset = 1'b0; idle_inputs();
   endtask

   task automatic test_basic();
      do_reset();
      tready = 1'b1;
      drive_retire(64'h0, NOP); step();
      n_vec++; if (o_tvalid !== 1'b1 || o_tpc !== 64'h0 || o_tseq !== 8'd0) begin n_err++; $display("FAIL basic_rec0 got v=%0b pc=%0h seq=%0d exp 1/0/0", o_tvalid, o_tpc, o_tseq); end
      n_vec++; if (o_tresult !== 64'h1000 || o_tinstr !== NOP) begin n_err++; $display("FAIL basic_rec0_data got res=%0h ins=%0h exp 1000/13", o_tresult, o_tinstr); end
      drive_retire(64'h4, NOP); step();
      n_vec++; if (o_tpc !== 64'h4 || o_tseq !== 8'd1) begin n_err++; $display("FAIL basic_rec1 got pc=%0h seq=%0d exp 4/1", o_tpc, o_tseq); end
      drive_retire(64'h8, NOP); step();
      n_vec++; if (o_tpc !== 64'h8 || o_tseq !== 8'd2) begin n_err++; $display("FAIL basic_rec2 got pc=%0h seq=%0d exp 8/2", o_tpc, o_tseq); end
      valid_instr = 1'b0; step();
      n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL basic_empty got %0b exp 0", o_tvalid); end
      n_vec++; if (o_executed !== 8'd3) begin n_err++; $display("FAIL basic_executed got %0d exp 3", o_executed); end
      n_vec++; if (o_cycles !== 8'd4 || o_fetched !== 8'd4) begin n_err++; $display("FAIL basic_cycles got cyc=%0d fet=%0d exp 4/4", o_cycles, o_fetched); end
   endtask

   task automatic test_overflow();
      do_reset();
      tready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         drive_retire(64'(i * 4), NOP); step();
      end
      valid_instr = 1'b0;
      n_vec++; if (o_dropped !== 8'd2 || o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_dropped got drop=%0d ovf=%0b exp 2/1", o_dropped, o_overflow); end
      n_vec++; if (o_executed !== 8'(DEPTH + 2)) begin n_err++; $display("FAIL ovf_executed got %0d exp %0d", o_executed, DEPTH + 2); end
      tready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         n_vec++; if (o_tvalid !== 1'b1 || o_tseq !== 8'(k) || o_tpc !== 64'(k * 4)) begin n_err++; $display("FAIL ovf_pop%0d got v=%0b seq=%0d pc=%0h exp 1/%0d/%0h", k, o_tvalid, o_tseq, o_tpc, k, k * 4); end
         step();
      end
      n_vec++; if (o_tvalid !== 1'b0 || o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_drained got v=%0b ovf=%0b exp 0/1", o_tvalid, o_overflow); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      tready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive_retire(64'(i * 4), NOP); step();
      end
      tready = 1'b1;
      drive_retire(64'(DEPTH * 4), NOP); step();
      valid_instr = 1'b0;
      n_vec++; if (o_dropped !== 8'd0 || o_overflow !== 1'b0) begin n_err++; $display("FAIL fullpp_nodrop got drop=%0d ovf=%0b exp 0/0", o_dropped, o_overflow); end
      n_vec++; if (o_executed !== 8'(DEPTH + 1)) begin n_err++; $display("FAIL fullpp_executed got %0d exp %0d", o_executed, DEPTH + 1); end
      for (int k = 1; k <= DEPTH; k++) begin
         n_vec++; if (o_tvalid !== 1'b1 || o_tseq !== 8'(k) || o_tpc !== 64'(k * 4)) begin n_err++; $display("FAIL fullpp_pop%0d got v=%0b seq=%0d pc=%0h exp 1/%0d/%0h", k, o_tvalid, o_tseq, o_tpc, k, k * 4); end
         step();
      end
      n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL fullpp_empty got %0b exp 0", o_tvalid); end
   endtask

   task automatic test_stall_flush();
      do_reset();
      tready = 1'b0;
      stall_mem = 1'b1; stall_if = 1'b1; flush_ex = 1'b1; stall_ex = 1'b0; step();
      stall_mem = 1'b0; stall_if = 1'b0; flush_ex = 1'b1; stall_ex = 1'b1;
      drive_retire(64'h100, NOP); step();
      n_vec++; if (o_tvalid !== 1'b0 || o_executed !== 8'd0) begin n_err++; $display("FAIL stall_mem_noretire got v=%0b exe=%0d exp 0/0", o_tvalid, o_executed); end
      flush_mem = 1'b1; stall_if = 1'b1; flush_ex = 1'b0; stall_ex = 1'b0;
      drive_retire(64'h180, NOP); step();
      n_vec++; if (o_tvalid !== 1'b0 || o_executed !== 8'd0) begin n_err++; $display("FAIL flush_mem_noretire got v=%0b exe=%0d exp 0/0", o_tvalid, o_executed); end
      flush_mem = 1'b0;
      drive_retire(64'h200, NOP); step();
      valid_instr = 1'b0;
      n_vec++; if (o_tvalid !== 1'b1 || o_tpc !== 64'h200 || o_tseq !== 8'd0) begin n_err++; $display("FAIL stall_retire got v=%0b pc=%0h seq=%0d exp 1/200/0", o_tvalid, o_tpc, o_tseq); end
      n_vec++; if (o_executed !== 8'd1) begin n_err++; $display("FAIL stall_executed got %0d exp 1", o_executed); end
      n_vec++; if (o_fetched !== 8'd1 || o_cycles !== 8'd4) begin n_err++; $display("FAIL stall_fetched got fet=%0d cyc=%0d exp 1/4", o_fetched, o_cycles); end
      n_vec++; if (o_flushed_ex !== 8'd1) begin n_err++; $display("FAIL flushed_ex got %0d exp 1", o_flushed_ex); end
      stall_if = 1'b0;
   endtask

   task automatic test_disable();
      do_reset();
      tready = 1'b0; enable = 1'b0;
      drive_retire(64'h300, NOP);
      repeat (3) step();
      n_vec++; if (o_tvalid !== 1'b0 || o_executed !== 8'd0 || o_cycles !== 8'd0 || o_fetched !== 8'd0) begin n_err++; $display("FAIL disable_frozen got v=%0b exe=%0d cyc=%0d fet=%0d exp 0/0/0/0", o_tvalid, o_executed, o_cycles, o_fetched); end
      enable = 1'b1; valid_instr = 1'b0; step();
      n_vec++; if (o_cycles !== 8'd1) begin n_err++; $display("FAIL disable_resume got %0d exp 1", o_cycles); end
   endtask

   task automatic test_halt_drain();
      do_reset();
      tready = 1'b0;
      drive_retire(64'h0, NOP); step();
      drive_retire(64'h4, NOP); step();
      drive_retire(64'h8, NOP); step();
      drive_retire(64'hC, HALT); step();
      drive_retire(64'h100, NOP);
      repeat (5) step();
      n_vec++; if (o_dbg_state !== 2'd1 || o_done !== 1'b0) begin n_err++; $display("FAIL halt_drain_state got st=%0d done=%0b exp 1/0", o_dbg_state, o_done); end
      n_vec++; if (o_executed !== 8'd4 || o_tseq !== 8'd0) begin n_err++; $display("FAIL halt_ignored got exe=%0d seq=%0d exp 4/0", o_executed, o_tseq); end
      n_vec++; if (o_cycles !== 8'd9) begin n_err++; $display("FAIL halt_cycles_drain got %0d exp 9", o_cycles); end
      tready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_vec++; if (o_done !== 1'b0 || o_tvalid !== 1'b1 || o_tseq !== 8'(k)) begin n_err++; $display("FAIL halt_pop%0d got done=%0b v=%0b seq=%0d exp 0/1/%0d", k, o_done, o_tvalid, o_tseq, k); end
         if (k == 3) begin
            n_vec++; if (o_tinstr !== HALT) begin n_err++; $display("FAIL halt_record got %0h exp %0h", o_tinstr, HALT); end
         end
         step();
      end
      n_vec++; if (o_done !== 1'b1 || o_tvalid !== 1'b0) begin n_err++; $display("FAIL halt_done got done=%0b v=%0b exp 1/0", o_done, o_tvalid); end
      n_vec++; if (o_cycles !== 8'd13) begin n_err++; $display("FAIL halt_cycles_final got %0d exp 13", o_cycles); end
      repeat (3) step();
      n_vec++; if (o_cycles !== 8'd13 || o_done !== 1'b1 || o_executed !== 8'd4) begin n_err++; $display("FAIL done_frozen got cyc=%0d done=%0b exe=%0d exp 13/1/4", o_cycles, o_done, o_executed); end
      valid_instr = 1'b0;
   endtask

   task automatic test_reset_in_drain();
      do_reset();
      tready = 1'b0;
      drive_retire(64'h0, NOP); step();
      drive_retire(64'h4, NOP); step();
      drive_retire(64'h8, HALT); step();
      valid_instr = 1'b0; step();
      n_vec++; if (o_dbg_state !== 2'd1 || o_tvalid !== 1'b1) begin n_err++; $display("FAIL rst_drain_pre got st=%0d v=%0b exp 1/1", o_dbg_state, o_tvalid); end
      reset = 1'b1; step();
      n_vec++; if (o_tvalid !== 1'b0 || o_done !== 1'b0 || o_dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_drain_state got v=%0b done=%0b st=%0d exp 0/0/0", o_tvalid, o_done, o_dbg_state); end
      n_vec++; if (o_cycles !== '0 || o_executed !== '0 || o_fetched !== '0 || o_flushed_ex !== '0 || o_dropped !== '0) begin n_err++; $display("FAIL rst_drain_counters got cyc=%0d exe=%0d fet=%0d exp 0/0/0", o_cycles, o_executed, o_fetched); end
      reset = 1'b0;
      drive_retire(64'h40, NOP); step();
      valid_instr = 1'b0;
      n_vec++; if (o_tvalid !== 1'b1 || o_tseq !== 8'd0 || o_tpc !== 64'h40) begin n_err++; $display("FAIL rst_drain_first got v=%0b seq=%0d pc=%0h exp 1/0/40", o_tvalid, o_tseq, o_tpc); end
   endtask

   task automatic test_saturate();
      do_reset();
      repeat (300) step();
      n_vec++; if (o_cycles !== 8'hFF || o_fetched !== 8'hFF) begin n_err++; $display("FAIL saturate got cyc=%0d fet=%0d exp 255/255", o_cycles, o_fetched); end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_stall_flush();
      test_disable();
      test_halt_drain();
      test_reset_in_drain();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_retire_trace_tx.md
RISCV_RETIRE_TRACE_TX -- requirements
Module: riscv_retire_trace_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, PC/result width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, trace FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter CNT_WIDTH, default 32, width of every statistic counter.
REQ-005 SHALL have parameter HALT_INSTR, default 32'h00100073, encoding that ends the trace.
REQ-006 SHALL have ports:
  i_clk  in  1  single clock, all logic on rising edge
  i_reset  in  1  synchronous, active-high reset
  i_enable  in  1  core enable; when 0 no state or counter changes except reset
  i_valid_instr  in  1  MEM stage holds a valid instruction
  i_flush_mem  in  1  MEM stage flushed this cycle
  i_stall_mem  in  1  MEM stage stalled this cycle
  i_stall_if  in  1  fetch stalled this cycle
  i_flush_ex  in  1  EX stage flushed this cycle
  i_stall_ex  in  1  EX stage stalled this cycle
  i_pc  in  DATA_WIDTH  PC of MEM-stage instruction
  i_instr  in  INSTR_WIDTH  MEM-stage instruction word
  i_result  in  DATA_WIDTH  ALU result of MEM-stage instruction
  o_tvalid  out  1  trace record available
  i_tready  in  1  consumer accepts record
  o_tpc / o_tinstr / o_tresult  out  DATA_WIDTH / INSTR_WIDTH / DATA_WIDTH  record fields
  o_tseq  out  CNT_WIDTH  retire sequence number of record
  o_cycles / o_fetched / o_executed / o_flushed_ex / o_dropped  out  CNT_WIDTH each  statistics
  o_overflow  out  1  sticky: at least one record dropped
  o_done  out  1  halt retired and FIFO drained

Function
REQ-007 SHALL register i_stall_mem each enabled cycle into was_stall_mem (reset 0).
REQ-008 SHALL define retire = i_enable & i_valid_instr & ~i_flush_mem & ~was_stall_mem.
REQ-009 SHALL, on retire in state RUN, push {i_pc, i_instr, i_result, seq} into FIFO, seq = o_executed value before increment.
REQ-010 SHALL make a pushed record visible on o_tvalid the cycle after push (1-cycle latency), FIFO order preserved.
REQ-011 SHALL pop on o_tvalid & i_tready; o_t* SHALL be stable while o_tvalid & ~i_tready.
REQ-012 SHALL allow simultaneous push and pop when full: pop frees the slot, push succeeds, no drop.
REQ-013 SHALL, on retire with FIFO full and no pop, drop the record, increment o_dropped, set o_overflow; o_executed still increments.
REQ-014 SHALL wrap FIFO pointers modulo FIFO_DEPTH with an extra bit distinguishing full from empty.
REQ-015 SHALL, each enabled cycle in RUN or DRAIN, increment o_cycles; o_fetched if ~i_stall_if; o_flushed_ex if i_flush_ex & ~i_stall_ex; o_executed on retire in RUN.
REQ-016 SHALL saturate every counter at all-ones (no wrap).
REQ-017 SHALL implement FSM RUN -> DRAIN -> DONE: RUN->DRAIN on retire of i_instr==HALT_INSTR (record is pushed); DRAIN->DONE when FIFO empty; DONE holds until reset.
REQ-018 SHALL ignore retire events in DRAIN and DONE (no push, no counter change).
REQ-019 SHALL freeze all counters in DONE; o_done = (state==DONE).
REQ-020 SHALL keep o_tvalid = ~fifo_empty in all states, including DRAIN.

Reset
REQ-021 SHALL, on i_reset high at a clock edge, regardless of i_enable or state, set: state RUN, FIFO empty, o_tvalid 0, o_t* 0, all counters 0, o_overflow 0, o_done 0, was_stall_mem 0.
REQ-022 SHALL discard in-flight FIFO contents on reset mid-operation; first post-reset record has o_tseq 0.

Verification
REQ-023 Three retires (pc 0x0,0x4,0x8), i_tready=1 -> three records, o_tseq 0,1,2, each one cycle after retire; o_executed=3.
REQ-024 i_tready=0, FIFO_DEPTH+2 retires -> o_dropped=2, o_overflow=1, o_executed=FIFO_DEPTH+2; subsequent pops return seq 0..FIFO_DEPTH-1.
REQ-025 Retire with i_stall_mem=1 previous cycle, or i_flush_mem=1 -> no push, o_executed unchanged; o_fetched counts only cycles with i_stall_if=0.
REQ-026 Retire HALT_INSTR with 3 queued records, i_tready held 0 for 5 cycles then 1 -> o_done rises the cycle after the 4th pop; o_cycles frozen thereafter.
REQ-027 Assert i_reset during DRAIN with FIFO non-empty -> next cycle o_tvalid=0, o_done=0, all counters 0; next retire gives o_tseq 0.
